// File: rtl/fir_out_decim.sv
// Decimates an offset-binary FIR result stream, converts it to two's complement and
// buffers it in a FIFO with sticky overflow; define FIR_OUT_DROP_CNT_EN for a drop counter.
module fir_out_decim #(
    parameter int OUT_WIDTH  = 16,
    parameter int OSR        = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [OUT_WIDTH-1:0]          in_data,
    input  logic                          in_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    input  logic                          ovf_clr
`ifdef FIR_OUT_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

    logic [PW-1:0]        phase;
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic accept;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    assign empty  = (level == '0);
    assign full   = (level == LW'(FIFO_DEPTH));
    assign accept = in_valid && (phase == '0);
    assign pop    = !empty && out_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign out_valid = !empty;
    // Gate the head so out_data reads zero whenever the FIFO holds nothing, including in reset.
    assign out_data  = empty ? '0 : mem[rptr];

    // Any gap in in_valid restarts the decimation phase so the next valid sample is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (!in_valid || phase == PW'(OSR - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {~in_data[OUT_WIDTH-1], in_data[OUT_WIDTH-2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef FIR_OUT_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed self-checking bench for fir_out_decim: one OSR=1 and one OSR=4 instance.
module tb_fir_out_decim;

    logic        clk;
    logic        rst;

    logic [15:0] in_data1, out_data1;
    logic        in_valid1, out_valid1, out_ready1, ovf1, ovf_clr1;
    logic [3:0]  level1;
    logic [15:0] in_data4, out_data4;
    logic        in_valid4, out_valid4, out_ready4, ovf4, ovf_clr4;
    logic [3:0]  level4;
`ifdef FIR_OUT_DROP_CNT_EN
    logic [15:0] drop_cnt1, drop_cnt4;
`endif

    int checks = 0;
    int errors = 0;

    fir_out_decim #(.OUT_WIDTH(16), .OSR(1), .FIFO_DEPTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .level(level1), .ovf(ovf1), .ovf_clr(ovf_clr1)
`ifdef FIR_OUT_DROP_CNT_EN
        , .drop_cnt(drop_cnt1)
`endif
    );

    fir_out_decim #(.OUT_WIDTH(16), .OSR(4), .FIFO_DEPTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .level(level4), .ovf(ovf4), .ovf_clr(ovf_clr4)
`ifdef FIR_OUT_DROP_CNT_EN
        , .drop_cnt(drop_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid1 !== 1'b0 || level1 !== 4'd0 || ovf1 !== 1'b0 || out_data1 !== 16'h0) begin
            errors++;
            $display("FAIL reset1: valid=%b level=%0d ovf=%b data=%h, want 0/0/0/0000",
                     out_valid1, level1, ovf1, out_data1);
        end
        checks++;
        if (out_valid4 !== 1'b0 || level4 !== 4'd0 || ovf4 !== 1'b0 || out_data4 !== 16'h0) begin
            errors++;
            $display("FAIL reset4: valid=%b level=%0d ovf=%b data=%h, want 0/0/0/0000",
                     out_valid4, level4, ovf4, out_data4);
        end
    endtask

    task automatic test_convert();
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 16'h8005;
        tick();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 16'h0005) begin
            errors++;
            $display("FAIL convert_pos: valid=%b data=%h, want 1/0005", out_valid1, out_data1);
        end
        in_data1 = 16'h7FFE;
        tick();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 16'hFFFE || level1 !== 4'd1) begin
            errors++;
            $display("FAIL convert_neg: valid=%b data=%h level=%0d, want 1/fffe/1",
                     out_valid1, out_data1, level1);
        end
        in_valid1 = 1'b0;
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || level1 !== 4'd0) begin
            errors++;
            $display("FAIL convert_drain: valid=%b level=%0d, want 0/0", out_valid1, level1);
        end
        out_ready1 = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid1 = 1'b1;
            in_data1  = 16'h8000 + 16'(k);
            tick();
        end
        in_valid1 = 1'b0;
        checks++;
        if (level1 !== 4'd8 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: level=%0d ovf=%b, want 8/1", level1, ovf1);
        end
`ifdef FIR_OUT_DROP_CNT_EN
        checks++;
        if (drop_cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL overflow_cnt: drop_cnt=%0d, want 2", drop_cnt1);
        end
`endif
        out_ready1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== 16'(k)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: valid=%b data=%h, want 1/%h",
                         k, out_valid1, out_data1, 16'(k));
            end
            tick();
        end
        out_ready1 = 1'b0;
        checks++;
        if (level1 !== 4'd0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty: level=%0d valid=%b, want 0/0", level1, out_valid1);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        out_ready1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1;
            in_data1  = 16'h8020 + 16'(i);
            tick();
        end
        // drop and clear in the same cycle: the drop must win
        in_data1 = 16'h8028;
        ovf_clr1 = 1'b1;
        tick();
        checks++;
        if (ovf1 !== 1'b1 || level1 !== 4'd8) begin
            errors++;
            $display("FAIL clr_vs_drop: ovf=%b level=%0d, want 1/8", ovf1, level1);
        end
`ifdef FIR_OUT_DROP_CNT_EN
        checks++;
        if (drop_cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL clr_vs_drop_cnt: drop_cnt=%0d, want 1", drop_cnt1);
        end
`endif
        in_valid1 = 1'b0;
        tick();
        ovf_clr1 = 1'b0;
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b, want 0", ovf1);
        end
`ifdef FIR_OUT_DROP_CNT_EN
        checks++;
        if (drop_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr: drop_cnt=%0d, want 0", drop_cnt1);
        end
`endif
        in_valid1  = 1'b1;
        in_data1   = 16'h8030;
        out_ready1 = 1'b1;
        tick();
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        checks++;
        if (level1 !== 4'd8 || ovf1 !== 1'b0 || out_data1 !== 16'h0021) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovf=%b data=%h, want 8/0/0021",
                     level1, ovf1, out_data1);
        end
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 16'h0021 + 16'(i) : 16'h0030;
            checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== exp) begin
                errors++;
                $display("FAIL full_drain[%0d]: valid=%b data=%h, want 1/%h",
                         i, out_valid1, out_data1, exp);
            end
            tick();
        end
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_data;
        logic [3:0]  exp_level;
        out_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid1 = 1'b1;
            in_data1  = 16'h8000 + 16'(i);
            tick();
        end
        in_valid1 = 1'b0;
        checks++;
        if (level1 !== 4'd5) begin
            errors++;
            $display("FAIL mid_fill: level=%0d, want 5", level1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || level1 !== 4'd0 || out_data1 !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b level=%0d data=%h, want 0/0/0000",
                     out_valid1, level1, out_data1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            in_valid1  = 1'b1;
            in_data1   = 16'h8040 + 16'(k - 1);
            out_ready1 = (k > 3);
            tick();
            exp_level = (k <= 3) ? 4'(k) : 4'd3;
            exp_data  = (k <= 3) ? 16'h0040 : 16'h0040 + 16'(k - 3);
            checks++;
            if (level1 !== exp_level || out_data1 !== exp_data) begin
                errors++;
                $display("FAIL wrap[%0d]: level=%0d data=%h, want %0d/%h",
                         k, level1, out_data1, exp_level, exp_data);
            end
        end
        in_valid1 = 1'b0;
        repeat (3) tick();
        out_ready1 = 1'b0;
        checks++;
        if (level1 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_drain: level=%0d, want 0", level1);
        end
    endtask

    task automatic test_decimate();
        logic [15:0] exp;
        out_ready4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 16'(i);
            tick();
            checks++;
            if (level4 !== 4'(i / 4 + 1)) begin
                errors++;
                $display("FAIL decim_level[%0d]: level=%0d, want %0d", i, level4, i / 4 + 1);
            end
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp = 16'h8000 + 16'(4 * j);
            checks++;
            if (out_valid4 !== 1'b1 || out_data4 !== exp) begin
                errors++;
                $display("FAIL decim_data[%0d]: valid=%b data=%h, want 1/%h",
                         j, out_valid4, out_data4, exp);
            end
            tick();
        end
        out_ready4 = 1'b0;
        checks++;
        if (level4 !== 4'd0) begin
            errors++;
            $display("FAIL decim_empty: level=%0d, want 0", level4);
        end
    endtask

    task automatic test_phase_restart();
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_data4   = 16'h0010;
        tick();
        in_data4 = 16'h0011;
        tick();
        in_valid4 = 1'b0;
        tick();
        checks++;
        if (level4 !== 4'd1) begin
            errors++;
            $display("FAIL restart_pre: level=%0d, want 1", level4);
        end
        in_valid4 = 1'b1;
        in_data4  = 16'h0013;
        tick();
        checks++;
        if (level4 !== 4'd2) begin
            errors++;
            $display("FAIL restart_accept: level=%0d, want 2", level4);
        end
        in_data4 = 16'h0014;
        tick();
        in_valid4 = 1'b0;
        checks++;
        if (level4 !== 4'd2) begin
            errors++;
            $display("FAIL restart_skip: level=%0d, want 2", level4);
        end
        out_ready4 = 1'b1;
        checks++;
        if (out_data4 !== 16'h8010) begin
            errors++;
            $display("FAIL restart_d0: data=%h, want 8010", out_data4);
        end
        tick();
        checks++;
        if (out_data4 !== 16'h8013) begin
            errors++;
            $display("FAIL restart_d1: data=%h, want 8013", out_data4);
        end
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        in_data1   = '0; in_valid1 = 1'b0; out_ready1 = 1'b0; ovf_clr1 = 1'b0;
        in_data4   = '0; in_valid4 = 1'b0; out_ready4 = 1'b0; ovf_clr4 = 1'b0;
        #12;
        test_reset();
        rst = 1'b1;
        tick();
        test_convert();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_decimate();
        test_phase_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
